// File: rtl/hub75_scan_reader.sv
// Scans a 2-bit-per-pixel frame RAM row by row into a HUB75 panel: shift, blank, latch, unblank.
// The next row is shifted while the previously latched row is on display.
module hub75_scan_reader #(
    parameter int COLUMNS        = 64,
    parameter int ROW_BITS       = 5,
    parameter int ADDR_WIDTH     = 11,
    parameter int DISPLAY_CYCLES = 256
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Enable,
    output logic [ADDR_WIDTH-1:0] RamAddress,
    output logic                  RamClockEn,
    input  logic [1:0]            RamData,
    output logic                  PanelClock,
    output logic                  PanelLatch,
    output logic                  PanelBlank,
    output logic [ROW_BITS-1:0]   RowSelect,
    output logic                  DataTop,
    output logic                  DataBottom,
    output logic                  FrameDone
);

    localparam int COL_BITS = $clog2(COLUMNS);
    localparam int TIMER_W  = $clog2(DISPLAY_CYCLES + 1);

    localparam logic [COL_BITS:0]     COL_END    = (COL_BITS + 1)'(COLUMNS);
    localparam logic [ROW_BITS-1:0]   ROW_LAST   = '1;
    localparam logic [TIMER_W-1:0]    TIMER_LOAD = TIMER_W'(DISPLAY_CYCLES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_BLANK  = 3'd3;
    localparam logic [2:0] S_LATCH  = 3'd4;
    localparam logic [2:0] S_SWITCH = 3'd5;

    logic [2:0]            state_q,        state_d;
    logic [COL_BITS:0]     column_q,       column_d;
    logic                  phase_q,        phase_d;
    logic [ROW_BITS-1:0]   load_row_q,     load_row_d;
    logic [TIMER_W-1:0]    timer_q,        timer_d;
    logic [ADDR_WIDTH-1:0] ram_address_q,  ram_address_d;
    logic                  ram_clock_en_q, ram_clock_en_d;
    logic                  panel_clock_q,  panel_clock_d;
    logic                  panel_latch_q,  panel_latch_d;
    logic                  panel_blank_q,  panel_blank_d;
    logic [ROW_BITS-1:0]   row_select_q,   row_select_d;
    logic                  data_top_q,     data_top_d;
    logic                  data_bottom_q,  data_bottom_d;
    logic                  frame_done_q,   frame_done_d;
    logic [COL_BITS:0]     column_inc;

    function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [ROW_BITS-1:0] row,
                                                        input logic [COL_BITS-1:0] col);
        return ADDR_WIDTH'({row, col});
    endfunction

    assign column_inc = column_q + 1'b1;

    // phase_q=0: address issued / panel clock high; phase_q=1: RAM word arrives and is registered.
    always_comb begin
        state_d        = state_q;
        column_d       = column_q;
        phase_d        = phase_q;
        load_row_d     = load_row_q;
        timer_d        = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
        ram_address_d  = ram_address_q;
        ram_clock_en_d = 1'b0;
        panel_clock_d  = 1'b0;
        panel_latch_d  = 1'b0;
        panel_blank_d  = panel_blank_q;
        row_select_d   = row_select_q;
        data_top_d     = data_top_q;
        data_bottom_d  = data_bottom_q;
        frame_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                panel_blank_d = 1'b1;
                if (Enable) begin
                    state_d        = S_SHIFT;
                    column_d       = '0;
                    phase_d        = 1'b0;
                    ram_address_d  = make_addr(load_row_q, '0);
                    ram_clock_en_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (!phase_q) begin
                    if (column_q == COL_END) begin
                        state_d = S_WAIT;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    data_top_d    = RamData[1];
                    data_bottom_d = RamData[0];
                    phase_d       = 1'b0;
                    column_d      = column_inc;
                    panel_clock_d = 1'b1;
                    if (column_inc != COL_END) begin
                        ram_address_d  = make_addr(load_row_q, column_inc[COL_BITS-1:0]);
                        ram_clock_en_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (timer_q == '0) begin
                    panel_blank_d = 1'b1;
                    state_d       = Enable ? S_BLANK : S_IDLE;
                end
            end
            S_BLANK: begin
                panel_latch_d = 1'b1;
                row_select_d  = load_row_q;
                state_d       = S_LATCH;
            end
            S_LATCH: begin
                panel_blank_d = 1'b0;
                frame_done_d  = (load_row_q == ROW_LAST);
                state_d       = S_SWITCH;
            end
            S_SWITCH: begin
                load_row_d     = load_row_q + 1'b1;
                timer_d        = TIMER_LOAD;
                column_d       = '0;
                phase_d        = 1'b0;
                ram_address_d  = make_addr(load_row_d, '0);
                ram_clock_en_d = 1'b1;
                state_d        = S_SHIFT;
            end
            default: begin
                state_d       = S_IDLE;
                panel_blank_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= S_IDLE;
            column_q       <= '0;
            phase_q        <= 1'b0;
            load_row_q     <= '0;
            timer_q        <= '0;
            ram_address_q  <= '0;
            ram_clock_en_q <= 1'b0;
            panel_clock_q  <= 1'b0;
            panel_latch_q  <= 1'b0;
            panel_blank_q  <= 1'b1;
            row_select_q   <= '0;
            data_top_q     <= 1'b0;
            data_bottom_q  <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            column_q       <= column_d;
            phase_q        <= phase_d;
            load_row_q     <= load_row_d;
            timer_q        <= timer_d;
            ram_address_q  <= ram_address_d;
            ram_clock_en_q <= ram_clock_en_d;
            panel_clock_q  <= panel_clock_d;
            panel_latch_q  <= panel_latch_d;
            panel_blank_q  <= panel_blank_d;
            row_select_q   <= row_select_d;
            data_top_q     <= data_top_d;
            data_bottom_q  <= data_bottom_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign RamAddress = ram_address_q;
    assign RamClockEn = ram_clock_en_q;
    assign PanelClock = panel_clock_q;
    assign PanelLatch = panel_latch_q;
    assign PanelBlank = panel_blank_q;
    assign RowSelect  = row_select_q;
    assign DataTop    = data_top_q;
    assign DataBottom = data_bottom_q;
    assign FrameDone  = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_reader.sv
// Bench for hub75_scan_reader: per-cycle vector table for the first row, pixel scoreboard fed by
// the RAM model, and sequences for overlap, frame wrap, enable drop, shift-bound timing and reset.
`timescale 1ns/1ps
module tb_hub75_scan_reader;

    typedef struct {
        logic       enable;
        logic [3:0] addr;
        logic       ram_en;
        logic       pclk;
        logic       latch;
        logic       blank;
        logic [1:0] row;
        logic [1:0] data;
        logic       fd;
    } vec_t;

    localparam logic [12:0] RESET_V = 13'h020;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Enable = 1'b0;
    logic       en_f = 1'b0;

    logic [3:0] RamAddress;
    logic       RamClockEn, PanelClock, PanelLatch, PanelBlank, DataTop, DataBottom, FrameDone;
    logic [1:0] RowSelect;
    logic [1:0] ram_data = 2'b00;

    logic [3:0] f_addr;
    logic       f_en, f_pc, f_lat, f_blank, f_top, f_bot, f_fd;
    logic [1:0] f_row;
    logic [1:0] ram_data_f = 2'b00;

    int n_checks = 0;
    int n_fail = 0;
    int pclk_rises = 0;
    int latch_count = 0;
    int fd_count = 0;
    logic [1:0] exp_q[$];
    logic [3:0] rd_log[$];
    vec_t tbl[16];

    always #5 Clock = ~Clock;

    hub75_scan_reader #(.COLUMNS(4), .ROW_BITS(2), .ADDR_WIDTH(4), .DISPLAY_CYCLES(20)) u_dut (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable),
        .RamAddress(RamAddress), .RamClockEn(RamClockEn), .RamData(ram_data),
        .PanelClock(PanelClock), .PanelLatch(PanelLatch), .PanelBlank(PanelBlank),
        .RowSelect(RowSelect), .DataTop(DataTop), .DataBottom(DataBottom), .FrameDone(FrameDone)
    );

    hub75_scan_reader #(.COLUMNS(4), .ROW_BITS(2), .ADDR_WIDTH(4), .DISPLAY_CYCLES(1)) u_fast (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(en_f),
        .RamAddress(f_addr), .RamClockEn(f_en), .RamData(ram_data_f),
        .PanelClock(f_pc), .PanelLatch(f_lat), .PanelBlank(f_blank),
        .RowSelect(f_row), .DataTop(f_top), .DataBottom(f_bot), .FrameDone(f_fd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [12:0] outv();
        return {RamAddress, RamClockEn, PanelClock, PanelLatch, PanelBlank, RowSelect,
                DataTop, DataBottom, FrameDone};
    endfunction

    function automatic logic [12:0] outv_f();
        return {f_addr, f_en, f_pc, f_lat, f_blank, f_row, f_top, f_bot, f_fd};
    endfunction

    function automatic vec_t mk(input int a, input int e, input int p, input int l,
                                input int b, input int r, input int d);
        vec_t v;
        v.enable = 1'b1;
        v.addr   = 4'(a);
        v.ram_en = 1'(e);
        v.pclk   = 1'(p);
        v.latch  = 1'(l);
        v.blank  = 1'(b);
        v.row    = 2'(r);
        v.data   = 2'(d);
        v.fd     = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic wait_latch(input string name, output logic [1:0] rs);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (PanelLatch !== 1'b1 && cyc < 200);
        check({name, "_latch_seen"}, PanelLatch, 1'b1);
        rs = RowSelect;
    endtask

    // RAM models: registered read, word at address a is a[1:0]
    initial forever begin
        @(posedge Clock);
        if (RamClockEn === 1'b1) begin
            ram_data <= RamAddress[1:0];
            exp_q.push_back(RamAddress[1:0]);
            rd_log.push_back(RamAddress);
        end
    end

    initial forever begin
        @(posedge Clock);
        if (f_en === 1'b1) ram_data_f <= f_addr[1:0];
    end

    // Scoreboard: every panel clock rising edge must present the next word read from the RAM
    initial begin
        logic pclk_prev;
        logic [1:0] e;
        pclk_prev = 1'b0;
        forever begin
            @(negedge Clock);
            if (!Reset_n) begin
                exp_q.delete();
                pclk_prev = 1'b0;
            end else begin
                if (PanelClock === 1'b1 && pclk_prev == 1'b0) begin
                    pclk_rises++;
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pixel", {DataTop, DataBottom}, e);
                    end
                end
                if (PanelLatch === 1'b1) begin
                    latch_count++;
                    check("latch_without_pclk", PanelClock, 1'b0);
                end
                if (FrameDone === 1'b1) fd_count++;
                pclk_prev = PanelClock;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rs;
        int run, cyc, rises0, latches0;
        int lt[$];

        tbl[0]  = mk(0, 1, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 0, 0);
        tbl[2]  = mk(1, 1, 1, 0, 1, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 1, 0, 0);
        tbl[4]  = mk(2, 1, 1, 0, 1, 0, 1);
        tbl[5]  = mk(2, 0, 0, 0, 1, 0, 1);
        tbl[6]  = mk(3, 1, 1, 0, 1, 0, 2);
        tbl[7]  = mk(3, 0, 0, 0, 1, 0, 2);
        tbl[8]  = mk(3, 0, 1, 0, 1, 0, 3);
        tbl[9]  = mk(3, 0, 0, 0, 1, 0, 3);
        tbl[10] = mk(3, 0, 0, 0, 1, 0, 3);
        tbl[11] = mk(3, 0, 0, 1, 1, 0, 3);
        tbl[12] = mk(3, 0, 0, 0, 0, 0, 3);
        tbl[13] = mk(4, 1, 0, 0, 0, 0, 3);
        tbl[14] = mk(4, 0, 0, 0, 0, 0, 3);
        tbl[15] = mk(5, 1, 1, 0, 0, 0, 0);

        // Reset held while Enable toggles
        for (int i = 0; i < 4; i++) begin
            Enable = i[0];
            tick();
            check($sformatf("reset_hold[%0d]", i), outv(), RESET_V);
        end
        Enable = 1'b0;
        Reset_n = 1'b1;
        tick();
        check("idle_after_reset", outv(), RESET_V);
        rd_log.delete();

        // First row, cycle by cycle from the SHIFT entry cycle
        for (int i = 0; i < 16; i++) begin
            Enable = tbl[i].enable;
            tick();
            check($sformatf("row0_vec[%0d]", i), outv(),
                  {tbl[i].addr, tbl[i].ram_en, tbl[i].pclk, tbl[i].latch, tbl[i].blank,
                   tbl[i].row, tbl[i].data, tbl[i].fd});
        end

        // Row 1 shifts while row 0 is displayed; blank has been low since SWITCH (4 cycles)
        run = 4;
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (PanelBlank === 1'b0) run++;
        end while (PanelLatch !== 1'b1 && cyc < 100);
        check("row1_latch_seen", PanelLatch, 1'b1);
        check("row1_rowselect", RowSelect, 2'd1);
        check("row1_blank_at_latch", PanelBlank, 1'b1);
        check("display_ge_20", (run >= 20), 1'b1);
        check("rows01_read_count", rd_log.size(), 8);
        for (int i = 0; i < 8 && i < rd_log.size(); i++)
            check($sformatf("rows01_addr[%0d]", i), rd_log[i], i);

        // Frame wrap after row 3
        wait_latch("row2", rs);
        check("row2_rowselect", rs, 2'd2);
        wait_latch("row3", rs);
        check("row3_rowselect", rs, 2'd3);
        check("no_framedone_yet", fd_count, 0);
        tick();
        check("framedone_in_switch", FrameDone, 1'b1);
        check("unblank_in_switch", PanelBlank, 1'b0);
        rd_log.delete();
        tick();
        check("framedone_one_cycle", FrameDone, 1'b0);
        check("framedone_count", fd_count, 1);
        wait_latch("wrap_row0", rs);
        check("wrap_rowselect", rs, 2'd0);
        check("wrap_read_count", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check($sformatf("wrap_addr[%0d]", i), rd_log[i], i);

        // Enable dropped during the row 2 shift
        wait_latch("row1b", rs);
        check("row1b_rowselect", rs, 2'd1);
        tick();
        tick();
        rises0 = pclk_rises;
        latches0 = latch_count;
        tick();
        tick();
        tick();
        Enable = 1'b0;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (PanelBlank !== 1'b1 && cyc < 100);
        check("drop_blanked", PanelBlank, 1'b1);
        check("drop_shift_completed", pclk_rises - rises0, 4);
        check("drop_rowselect_kept", RowSelect, 2'd1);
        check("drop_no_latch", latch_count - latches0, 0);
        for (int i = 0; i < 10; i++) tick();
        check("idle_no_pclk", pclk_rises - rises0, 4);
        check("idle_still_blank", PanelBlank, 1'b1);
        check("idle_no_ram_read", RamClockEn, 1'b0);

        // Re-enable, with a short Enable glitch inside the shift
        rd_log.delete();
        Enable = 1'b1;
        tick();
        tick();
        tick();
        Enable = 1'b0;
        tick();
        Enable = 1'b1;
        wait_latch("resume", rs);
        check("resume_rowselect", rs, 2'd2);
        check("resume_read_count", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check($sformatf("resume_addr[%0d]", i), rd_log[i], 8 + i);

        // Shift-bound instance: latch to latch = 2*4+1 SHIFT + 1 WAIT + 3
        en_f = 1'b1;
        cyc = 0;
        while (lt.size() < 3 && cyc < 200) begin
            tick();
            cyc++;
            if (f_lat === 1'b1) begin
                lt.push_back(cyc);
                check("fast_latch_no_pclk", f_pc, 1'b0);
                check("fast_latch_blank", f_blank, 1'b1);
            end
        end
        check("fast_latch_count", lt.size(), 3);
        if (lt.size() == 3) begin
            check("fast_period_a", lt[1] - lt[0], 13);
            check("fast_period_b", lt[2] - lt[1], 13);
        end

        // Asynchronous reset in the middle of a shift
        cyc = 0;
        while (PanelClock !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        check("midshift_reached", PanelClock, 1'b1);
        #1;
        Reset_n = 1'b0;
        #1;
        check("async_reset_main", outv(), RESET_V);
        check("async_reset_fast", outv_f(), RESET_V);
        tick();
        check("reset_held_main", outv(), RESET_V);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
